// File: rtl/vnlp_pkg.sv
// Shared VNLP constants: memory geometry, vector stride and loader state encoding.
package vnlp_pkg;

    localparam int unsigned ADDR_W   = 9;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned DEPTH    = 512;
    localparam int unsigned VEC_LEN  = 4;
    localparam int unsigned STRIDE   = VEC_LEN + 1;
    localparam int unsigned MAX_VECS = DEPTH / STRIDE;
    localparam int unsigned IDX_W    = $clog2(VEC_LEN);

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLEAR = 3'd1;
    localparam state_t ST_LOAD  = 3'd2;
    localparam state_t ST_FIRE  = 3'd3;
    localparam state_t ST_WAIT  = 3'd4;

endpackage

// File: rtl/vnlp_loader.sv
// Feeds the VNLP engine: clears its vector memory, writes stride-5 vectors from a
// valid/ready byte stream, then issues a Start pulse and waits for Done.
module vnlp_loader
    import vnlp_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load_Req,
    input  logic [DATA_W-1:0] In_Data,
    input  logic              In_Valid,
    input  logic              In_Last,
    output logic              In_Ready,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData,
    output logic              Mem_WE,
    output logic              Start,
    input  logic              Done,
    output logic              Busy,
    output logic [ADDR_W-1:0] Vec_Count,
    output logic              Overflow
);

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic [ADDR_W-1:0]   vec_count_q, vec_count_d;
    logic                overflow_q,  overflow_d;
    logic                in_ready_q,  in_ready_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q,    mem_we_d;
    logic                start_q,     start_d;
    logic                busy_q,      busy_d;

    logic                last_elem;

    assign last_elem = (idx_q == IDX_W'(VEC_LEN - 1));

    // Next-state and registered-output logic; write port is zeroed whenever idle.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        vec_count_d = vec_count_q;
        overflow_d  = overflow_q;
        in_ready_d  = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_we_d    = 1'b0;
        start_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Load_Req) begin
                    state_d     = ST_CLEAR;
                    mem_we_d    = 1'b1;
                    addr_d      = '0;
                    idx_d       = '0;
                    vec_count_d = '0;
                    overflow_d  = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (mem_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d    = ST_LOAD;
                    in_ready_d = 1'b1;
                end else begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end
            end
            ST_LOAD: begin
                in_ready_d = 1'b1;
                if (In_Valid && in_ready_q) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = In_Data;
                    // Separator word skipped: it already holds 0 from the clear pass.
                    if (last_elem) begin
                        addr_d = addr_q + ADDR_W'(2);
                        idx_d  = '0;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        idx_d  = idx_q + IDX_W'(1);
                    end
                    if (idx_q == '0) begin
                        vec_count_d = vec_count_q + ADDR_W'(1);
                    end
                    if (In_Last) begin
                        state_d    = ST_FIRE;
                        in_ready_d = 1'b0;
                    end else if (last_elem && (vec_count_q == ADDR_W'(MAX_VECS))) begin
                        state_d    = ST_FIRE;
                        in_ready_d = 1'b0;
                        overflow_d = 1'b1;
                    end
                end
            end
            ST_FIRE: begin
                start_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (Done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            idx_q       <= '0;
            vec_count_q <= '0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            vec_count_q <= vec_count_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
        end
    end

    assign In_Ready  = in_ready_q;
    assign Mem_Addr  = mem_addr_q;
    assign Mem_WData = mem_wdata_q;
    assign Mem_WE    = mem_we_q;
    assign Start     = start_q;
    assign Busy      = busy_q;
    assign Vec_Count = vec_count_q;
    assign Overflow  = overflow_q;

endmodule

// File: tb/tb_vnlp_loader.sv
// Directed bench for vnlp_loader with a write-port memory model and Start monitor.
module tb_vnlp_loader;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Load_Req = 1'b0;
    logic [7:0] In_Data = 8'd0;
    logic       In_Valid = 1'b0;
    logic       In_Last = 1'b0;
    logic       Done = 1'b0;
    logic       In_Ready;
    logic [8:0] Mem_Addr;
    logic [7:0] Mem_WData;
    logic       Mem_WE;
    logic       Start;
    logic       Busy;
    logic [8:0] Vec_Count;
    logic       Overflow;

    int checks = 0;
    int errors = 0;

    vnlp_loader dut (
        .Clk(Clk), .Reset(Reset), .Load_Req(Load_Req),
        .In_Data(In_Data), .In_Valid(In_Valid), .In_Last(In_Last), .In_Ready(In_Ready),
        .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .Mem_WE(Mem_WE),
        .Start(Start), .Done(Done), .Busy(Busy),
        .Vec_Count(Vec_Count), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    // Memory model of M1 plus write/start bookkeeping.
    logic [7:0]  mem_m [0:511];
    int unsigned wr_cnt = 0;
    int unsigned start_cnt = 0;
    int unsigned cyc = 0;
    int unsigned last_we_cyc = 0;
    int unsigned start_cyc = 0;
    logic [8:0]  last_wr_addr = 9'd0;

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (Mem_WE === 1'b1) begin
            mem_m[Mem_Addr] <= Mem_WData;
            wr_cnt          <= wr_cnt + 1;
            last_we_cyc     <= cyc;
            last_wr_addr    <= Mem_Addr;
        end
        if (Start === 1'b1) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_load();
        int unsigned w0;
        int nz;
        @(negedge Clk);
        w0 = wr_cnt;
        Load_Req = 1'b1;
        @(negedge Clk);
        Load_Req = 1'b0;
        checks++;
        if (Mem_WE !== 1'b1 || Mem_Addr !== 9'd0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_first: we=%b addr=%0d busy=%b, want we=1 addr=0 busy=1", Mem_WE, Mem_Addr, Busy);
        end
        checks++;
        if (Vec_Count !== 9'd0 || Overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_zero_counts: vec_count=%0d overflow=%b, want 0 0", Vec_Count, Overflow);
        end
        repeat (511) @(negedge Clk);
        checks++;
        if (Mem_WE !== 1'b1 || Mem_Addr !== 9'd511 || In_Ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_last: we=%b addr=%0d ready=%b, want we=1 addr=511 ready=0", Mem_WE, Mem_Addr, In_Ready);
        end
        @(negedge Clk);
        checks++;
        if (In_Ready !== 1'b1 || Mem_WE !== 1'b0) begin
            errors++;
            $display("FAIL load_entry: ready=%b we=%b, want ready=1 we=0", In_Ready, Mem_WE);
        end
        checks++;
        if (wr_cnt - w0 != 512) begin
            errors++;
            $display("FAIL clear_count: writes=%0d, want 512", wr_cnt - w0);
        end
        nz = 0;
        for (int i = 0; i < 512; i++) if (mem_m[i] !== 8'h00) nz++;
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL clear_contents: nonzero words=%0d, want 0", nz);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        In_Data  = d;
        In_Valid = 1'b1;
        In_Last  = last;
        while (In_Ready !== 1'b1 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: In_Ready stayed %b for data %0d, want 1", In_Ready, d);
        end
        @(negedge Clk);
        In_Valid = 1'b0;
        In_Last  = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        checks++;
        if ({In_Ready, Mem_WE, Start, Busy, Overflow} !== 5'b0 || Mem_Addr !== 9'd0 ||
            Mem_WData !== 8'd0 || Vec_Count !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b we=%b start=%b busy=%b ovf=%b addr=%0d wdata=%0d vc=%0d, want all 0",
                     In_Ready, Mem_WE, Start, Busy, Overflow, Mem_Addr, Mem_WData, Vec_Count);
        end
        Reset = 1'b0;
    endtask

    task automatic test_two_vectors();
        logic [7:0] d [8] = '{8'd49, 8'd34, 8'd33, 8'd23, 8'd17, 8'd40, 8'd19, 8'd102};
        logic [7:0] e [10] = '{8'd49, 8'd34, 8'd33, 8'd23, 8'd0, 8'd17, 8'd40, 8'd19, 8'd102, 8'd0};
        int unsigned w0, s0;
        start_load();
        w0 = wr_cnt;
        s0 = start_cnt;
        for (int k = 0; k < 8; k++) send(d[k], (k == 7));
        checks++;
        if (Mem_WE !== 1'b1 || Mem_Addr !== 9'd8 || Mem_WData !== 8'd102 || Start !== 1'b0) begin
            errors++;
            $display("FAIL two_last_write: we=%b addr=%0d data=%0d start=%b, want 1 8 102 0", Mem_WE, Mem_Addr, Mem_WData, Start);
        end
        @(negedge Clk);
        checks++;
        if (Start !== 1'b1 || Mem_WE !== 1'b0) begin
            errors++;
            $display("FAIL two_start: start=%b we=%b, want start=1 we=0", Start, Mem_WE);
        end
        for (int a = 0; a < 10; a++) begin
            checks++;
            if (mem_m[a] !== e[a]) begin
                errors++;
                $display("FAIL two_mem[%0d]: got %0d, want %0d", a, mem_m[a], e[a]);
            end
        end
        checks++;
        if (Vec_Count !== 9'd2 || Overflow !== 1'b0 || wr_cnt - w0 != 8) begin
            errors++;
            $display("FAIL two_counts: vc=%0d ovf=%b writes=%0d, want 2 0 8", Vec_Count, Overflow, wr_cnt - w0);
        end
        repeat (4) @(negedge Clk);
        checks++;
        if (Busy !== 1'b1 || Start !== 1'b0 || start_cnt - s0 != 1 || start_cyc != last_we_cyc + 1) begin
            errors++;
            $display("FAIL two_wait: busy=%b start=%b pulses=%0d gap=%0d, want 1 0 1 1",
                     Busy, Start, start_cnt - s0, start_cyc - last_we_cyc);
        end
        Done = 1'b1;
        @(negedge Clk);
        Done = 1'b0;
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL two_done: busy=%b, want 0", Busy);
        end
    endtask

    task automatic test_partial();
        int unsigned s0;
        start_load();
        s0 = start_cnt;
        send(8'd11, 1'b0);
        send(8'd6, 1'b1);
        repeat (2) @(negedge Clk);
        checks++;
        if (mem_m[0] !== 8'd11 || mem_m[1] !== 8'd6 || mem_m[2] !== 8'd0 || mem_m[3] !== 8'd0) begin
            errors++;
            $display("FAIL partial_mem: %0d %0d %0d %0d, want 11 6 0 0", mem_m[0], mem_m[1], mem_m[2], mem_m[3]);
        end
        checks++;
        if (Vec_Count !== 9'd1 || start_cnt - s0 != 1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL partial_counts: vc=%0d pulses=%0d busy=%b, want 1 1 1", Vec_Count, start_cnt - s0, Busy);
        end
        Done = 1'b1;
        @(negedge Clk);
        Done = 1'b0;
    endtask

    task automatic test_overflow();
        int unsigned w0, s0;
        int acc;
        start_load();
        w0 = wr_cnt;
        s0 = start_cnt;
        acc = 0;
        for (int i = 0; i < 412; i++) begin
            In_Data  = 8'(i + 1);
            In_Valid = 1'b1;
            In_Last  = 1'b0;
            if (i == 407 || i == 408) begin
                checks++;
                if (In_Ready !== ((i == 407) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL ovf_ready_at_%0d: ready=%b, want %b", i, In_Ready, (i == 407) ? 1'b1 : 1'b0);
                end
            end
            if (In_Ready === 1'b1) acc++;
            @(negedge Clk);
        end
        In_Valid = 1'b0;
        checks++;
        if (acc != 408 || wr_cnt - w0 != 408 || last_wr_addr !== 9'd508) begin
            errors++;
            $display("FAIL ovf_writes: accepted=%0d writes=%0d last_addr=%0d, want 408 408 508", acc, wr_cnt - w0, last_wr_addr);
        end
        checks++;
        if (mem_m[508] !== 8'd152 || mem_m[505] !== 8'd149 || mem_m[504] !== 8'd0) begin
            errors++;
            $display("FAIL ovf_tail: m508=%0d m505=%0d m504=%0d, want 152 149 0", mem_m[508], mem_m[505], mem_m[504]);
        end
        checks++;
        if (mem_m[509] !== 8'd0 || mem_m[510] !== 8'd0 || mem_m[511] !== 8'd0) begin
            errors++;
            $display("FAIL ovf_unwritten: m509=%0d m510=%0d m511=%0d, want 0 0 0", mem_m[509], mem_m[510], mem_m[511]);
        end
        checks++;
        if (Overflow !== 1'b1 || Vec_Count !== 9'd102 || In_Ready !== 1'b0) begin
            errors++;
            $display("FAIL ovf_flags: ovf=%b vc=%0d ready=%b, want 1 102 0", Overflow, Vec_Count, In_Ready);
        end
        checks++;
        if (start_cnt - s0 != 1 || start_cyc != last_we_cyc + 1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_start: pulses=%0d gap=%0d busy=%b, want 1 1 1", start_cnt - s0, start_cyc - last_we_cyc, Busy);
        end
        Done = 1'b1;
        @(negedge Clk);
        Done = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_done: busy=%b ovf=%b, want 0 1", Busy, Overflow);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] e [10] = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd0, 8'd9, 8'd10, 8'd11, 8'd12, 8'd0};
        int unsigned w0, s0;
        start_load();
        w0 = wr_cnt;
        s0 = start_cnt;
        for (int k = 0; k < 8; k++) begin
            In_Valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            if (k == 3) begin
                Load_Req = 1'b1;
                Done     = 1'b1;
            end
            send(8'(k + 5), (k == 7));
            Load_Req = 1'b0;
            Done     = 1'b0;
            if (k == 5) begin
                checks++;
                if (Busy !== 1'b1 || In_Ready !== 1'b1 || start_cnt - s0 != 0) begin
                    errors++;
                    $display("FAIL bp_midload: busy=%b ready=%b pulses=%0d, want 1 1 0", Busy, In_Ready, start_cnt - s0);
                end
            end
        end
        repeat (2) @(negedge Clk);
        for (int a = 0; a < 10; a++) begin
            checks++;
            if (mem_m[a] !== e[a]) begin
                errors++;
                $display("FAIL bp_mem[%0d]: got %0d, want %0d", a, mem_m[a], e[a]);
            end
        end
        checks++;
        if (wr_cnt - w0 != 8 || Vec_Count !== 9'd2 || start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL bp_counts: writes=%0d vc=%0d pulses=%0d, want 8 2 1", wr_cnt - w0, Vec_Count, start_cnt - s0);
        end
        Done = 1'b1;
        @(negedge Clk);
        Done = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        int unsigned s0;
        start_load();
        s0 = start_cnt;
        for (int k = 0; k < 6; k++) send(8'(k + 1), 1'b0);
        checks++;
        if (Vec_Count !== 9'd2) begin
            errors++;
            $display("FAIL rst_pre_vc: vc=%0d, want 2", Vec_Count);
        end
        Reset = 1'b1;
        Done  = 1'b1;
        @(negedge Clk);
        checks++;
        if ({In_Ready, Mem_WE, Start, Busy, Overflow} !== 5'b0 || Mem_Addr !== 9'd0 ||
            Mem_WData !== 8'd0 || Vec_Count !== 9'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: ready=%b we=%b start=%b busy=%b ovf=%b addr=%0d wdata=%0d vc=%0d, want all 0",
                     In_Ready, Mem_WE, Start, Busy, Overflow, Mem_Addr, Mem_WData, Vec_Count);
        end
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        Done = 1'b0;
        checks++;
        if (Busy !== 1'b0 || start_cnt - s0 != 0) begin
            errors++;
            $display("FAIL rst_mid_idle: busy=%b pulses=%0d, want 0 0", Busy, start_cnt - s0);
        end
        start_load();
        send(8'd7, 1'b1);
        repeat (2) @(negedge Clk);
        checks++;
        if (mem_m[0] !== 8'd7 || mem_m[1] !== 8'd0 || Vec_Count !== 9'd1 || start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL rst_reload: m0=%0d m1=%0d vc=%0d pulses=%0d, want 7 0 1 1", mem_m[0], mem_m[1], Vec_Count, start_cnt - s0);
        end
        Done = 1'b1;
        @(negedge Clk);
        Done = 1'b0;
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_reload_done: busy=%b, want 0", Busy);
        end
    endtask

    initial begin
        test_reset();
        test_two_vectors();
        test_partial();
        test_overflow();
        test_backpressure();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
